// File: rtl/mem_loader_pkg.sv
// Shared types and default widths for the load/run/unload controller.
package mem_loader_pkg;

    localparam int unsigned DEF_D  = 8;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RUN    = 3'd2,
        S_UNLOAD = 3'd3,
        S_FIN    = 3'd4
    } ldr_state_t;

endpackage

// File: rtl/mem_loader_if.sv
// Host, core and memory-port signals of mem_loader; slave = loader side, master = environment side.
interface mem_loader_if
    import mem_loader_pkg::*;
#(
    parameter int unsigned D = DEF_D
);
    logic              Start;
    logic [DATA_W-1:0] InData;
    logic              InValid;
    logic              InReady;
    logic [DATA_W-1:0] OutData;
    logic              OutValid;
    logic              OutReady;
    logic              CoreReset;
    logic              CoreDone;
    logic              MemOwn;
    logic [D-1:0]      MemAddr;
    logic              MemWriteEn;
    logic [DATA_W-1:0] MemWriteData;
    logic [DATA_W-1:0] MemReadData;
    logic              Busy;
    logic              Finished;
    logic              Timeout;
    logic [CNT_W-1:0]  CycleCount;

    modport slave (
        input  Start, InData, InValid, OutReady, CoreDone, MemReadData,
        output InReady, OutData, OutValid, CoreReset, MemOwn, MemAddr,
               MemWriteEn, MemWriteData, Busy, Finished, Timeout, CycleCount
    );

    modport master (
        output Start, InData, InValid, OutReady, CoreDone, MemReadData,
        input  InReady, OutData, OutValid, CoreReset, MemOwn, MemAddr,
               MemWriteEn, MemWriteData, Busy, Finished, Timeout, CycleCount
    );
endinterface

// File: rtl/mem_loader_xfer_counter.sv
// Transfer pointer shared by LOAD and UNLOAD: D+1 bits so a full 2^D window is countable.
module xfer_counter #(
    parameter int unsigned D = 8
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         clr_i,
    input  logic         inc_i,
    input  logic [D:0]   last_i,
    output logic [D-1:0] idx_o,
    output logic         tc_o
);
    localparam logic [D:0] ONE = (D+1)'(1);

    logic [D:0] cnt_q;
    logic [D:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + ONE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign idx_o = cnt_q[D-1:0];
    assign tc_o  = (cnt_q == last_i);

endmodule

// File: rtl/mem_loader.sv
// Load/run/unload controller: streams an image into data memory, runs the core, streams a result window out.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int unsigned     D           = DEF_D,
    parameter int unsigned     LOAD_BASE   = 0,
    parameter int unsigned     LOAD_LEN    = 64,
    parameter int unsigned     UNLOAD_BASE = 64,
    parameter int unsigned     UNLOAD_LEN  = 64,
    parameter logic [CNT_W-1:0] MAX_CYCLES = 16'hFFFF
) (
    input logic         Clk,
    input logic         Reset,
    mem_loader_if.slave bus
);
    localparam int unsigned PW = D + 1;

    localparam logic [2:0] IDLE   = S_IDLE;
    localparam logic [2:0] LOAD   = S_LOAD;
    localparam logic [2:0] RUN    = S_RUN;
    localparam logic [2:0] UNLOAD = S_UNLOAD;
    localparam logic [2:0] FIN    = S_FIN;

    localparam logic [D-1:0]     LOAD_BASE_A   = D'(LOAD_BASE);
    localparam logic [D-1:0]     UNLOAD_BASE_A = D'(UNLOAD_BASE);
    localparam logic [PW-1:0]    LOAD_LAST     = PW'(LOAD_LEN - 1);
    localparam logic [PW-1:0]    UNLOAD_LAST   = PW'(UNLOAD_LEN - 1);
    localparam logic [CNT_W-1:0] CYC_ONE       = CNT_W'(1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic             timeout_q, timeout_d;

    logic          ptr_clr;
    logic          ptr_inc;
    logic          ptr_tc;
    logic [PW-1:0] ptr_last;
    logic [D-1:0]  ptr_idx;

    assign ptr_last = (state_q == UNLOAD) ? UNLOAD_LAST : LOAD_LAST;

    xfer_counter #(.D(D)) u_ptr (
        .clk_i   (Clk),
        .rst_n_i (Reset),
        .clr_i   (ptr_clr),
        .inc_i   (ptr_inc),
        .last_i  (ptr_last),
        .idx_o   (ptr_idx),
        .tc_o    (ptr_tc)
    );

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        cycle_d   = cycle_q;
        timeout_d = timeout_q;
        ptr_clr   = 1'b0;
        ptr_inc   = 1'b0;
        case (state_q)
            IDLE, FIN: begin
                if (bus.Start) begin
                    state_d   = LOAD;
                    cycle_d   = '0;
                    timeout_d = 1'b0;
                    ptr_clr   = 1'b1;
                end
            end
            LOAD: begin
                if (bus.InValid) begin
                    ptr_inc = 1'b1;
                    if (ptr_tc) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (cycle_q != MAX_CYCLES) begin
                    cycle_d = cycle_q + CYC_ONE;
                end
                // Done wins over the limit when both land in the same cycle.
                if (bus.CoreDone) begin
                    state_d = UNLOAD;
                    ptr_clr = 1'b1;
                end else if (cycle_q == MAX_CYCLES) begin
                    state_d   = UNLOAD;
                    timeout_d = 1'b1;
                    ptr_clr   = 1'b1;
                end
            end
            UNLOAD: begin
                if (bus.OutReady) begin
                    ptr_inc = 1'b1;
                    if (ptr_tc) begin
                        state_d = FIN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q   <= IDLE;
            cycle_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cycle_q   <= cycle_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.InReady      = (state_q == LOAD);
    assign bus.MemWriteEn   = (state_q == LOAD) && bus.InValid;
    assign bus.MemWriteData = bus.InData;
    assign bus.MemAddr      = (state_q == UNLOAD) ? (UNLOAD_BASE_A + ptr_idx)
                                                  : (LOAD_BASE_A + ptr_idx);
    assign bus.OutValid     = (state_q == UNLOAD);
    assign bus.OutData      = bus.MemReadData;
    assign bus.CoreReset    = (state_q != RUN);
    assign bus.MemOwn       = (state_q != RUN);
    assign bus.Busy         = (state_q == LOAD) || (state_q == RUN) || (state_q == UNLOAD);
    assign bus.Finished     = (state_q == FIN);
    assign bus.Timeout      = timeout_q;
    assign bus.CycleCount   = cycle_q;

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: three configurations, random traffic, memory-image reference model.
module tb_mem_loader;
    import mem_loader_pkg::*;

    typedef struct {
        int d;
        int lb;
        int ll;
        int ub;
        int ul;
        int mx;
    } cfg_t;

    typedef struct packed {
        logic        in_ready;
        logic        out_valid;
        logic        core_reset;
        logic        mem_own;
        logic        mem_we;
        logic        busy;
        logic        finished;
        logic        timeout;
        logic [7:0]  out_data;
        logic [7:0]  addr;
        logic [15:0] cyc;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] start_v;
    logic [7:0] in_data;
    logic       in_valid;
    logic       out_ready;
    logic       core_done;
    logic       mem_clr;
    logic [1:0] sel;
    int         n_checks;
    int         n_fail;

    always #5 clk = ~clk;

    mem_loader_if #(.D(8)) if0 ();
    mem_loader_if #(.D(8)) if1 ();
    mem_loader_if #(.D(4)) if2 ();

    mem_loader #(.D(8), .LOAD_BASE(0), .LOAD_LEN(4), .UNLOAD_BASE(0), .UNLOAD_LEN(4),
                 .MAX_CYCLES(16'd10)) u_dut0 (.Clk(clk), .Reset(rst_n), .bus(if0));
    mem_loader #(.D(8), .LOAD_BASE(250), .LOAD_LEN(10), .UNLOAD_BASE(252), .UNLOAD_LEN(8),
                 .MAX_CYCLES(16'd40)) u_dut1 (.Clk(clk), .Reset(rst_n), .bus(if1));
    mem_loader #(.D(4), .LOAD_BASE(5), .LOAD_LEN(16), .UNLOAD_BASE(3), .UNLOAD_LEN(16),
                 .MAX_CYCLES(16'd7)) u_dut2 (.Clk(clk), .Reset(rst_n), .bus(if2));

    assign if0.Start = start_v[0];
    assign if0.InData = in_data;
    assign if0.InValid = in_valid;
    assign if0.OutReady = out_ready;
    assign if0.CoreDone = core_done;
    assign if1.Start = start_v[1];
    assign if1.InData = in_data;
    assign if1.InValid = in_valid;
    assign if1.OutReady = out_ready;
    assign if1.CoreDone = core_done;
    assign if2.Start = start_v[2];
    assign if2.InData = in_data;
    assign if2.InValid = in_valid;
    assign if2.OutReady = out_ready;
    assign if2.CoreDone = core_done;

    // Data memories seen by each loader; the core never writes in this bench.
    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];
    logic [7:0] mem2 [16];
    int         wr0, wr1, wr2;

    assign if0.MemReadData = mem0[if0.MemAddr];
    assign if1.MemReadData = mem1[if1.MemAddr];
    assign if2.MemReadData = mem2[if2.MemAddr];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem0[8'(i)] <= 8'h00;
            wr0 <= 0;
        end else if (if0.MemWriteEn) begin
            mem0[if0.MemAddr] <= if0.MemWriteData;
            wr0 <= wr0 + 1;
        end
    end

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem1[8'(i)] <= 8'h00;
            wr1 <= 0;
        end else if (if1.MemWriteEn) begin
            mem1[if1.MemAddr] <= if1.MemWriteData;
            wr1 <= wr1 + 1;
        end
    end

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) mem2[4'(i)] <= 8'h00;
            wr2 <= 0;
        end else if (if2.MemWriteEn) begin
            mem2[if2.MemAddr] <= if2.MemWriteData;
            wr2 <= wr2 + 1;
        end
    end

    obs_t o;
    always_comb begin
        case (sel)
            2'd0: o = {if0.InReady, if0.OutValid, if0.CoreReset, if0.MemOwn, if0.MemWriteEn,
                       if0.Busy, if0.Finished, if0.Timeout, if0.OutData, if0.MemAddr, if0.CycleCount};
            2'd1: o = {if1.InReady, if1.OutValid, if1.CoreReset, if1.MemOwn, if1.MemWriteEn,
                       if1.Busy, if1.Finished, if1.Timeout, if1.OutData, if1.MemAddr, if1.CycleCount};
            default: o = {if2.InReady, if2.OutValid, if2.CoreReset, if2.MemOwn, if2.MemWriteEn,
                          if2.Busy, if2.Finished, if2.Timeout, if2.OutData, 4'h0, if2.MemAddr,
                          if2.CycleCount};
        endcase
    end

    // Reference image: what each memory must hold, built only from the bytes the bench sent.
    logic [7:0] ref_mem [3][256];

    function automatic cfg_t cfg(input int k);
        cfg_t c;
        case (k)
            0:       c = '{d: 8, lb: 0,   ll: 4,  ub: 0,   ul: 4,  mx: 10};
            1:       c = '{d: 8, lb: 250, ll: 10, ub: 252, ul: 8,  mx: 40};
            default: c = '{d: 4, lb: 5,   ll: 16, ub: 3,   ul: 16, mx: 7};
        endcase
        return c;
    endfunction

    function automatic logic [7:0] mem_rd(input int k, input int a);
        case (k)
            0:       return mem0[8'(a)];
            1:       return mem1[8'(a)];
            default: return mem2[4'(a)];
        endcase
    endfunction

    function automatic int wr_count(input int k);
        case (k)
            0:       return wr0;
            1:       return wr1;
            default: return wr2;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_mem(input int k);
        cfg_t c;
        c = cfg(k);
        for (int a = 0; a < (1 << c.d); a++) begin
            check("mem_image", 32'(mem_rd(k, a)), 32'(ref_mem[k][8'(a)]));
        end
    endtask

    task automatic do_load(input int k, input bit rnd_valid, input int abort_after,
                           output int n_loaded);
        cfg_t       c;
        int         msk;
        int         n;
        int         t;
        int         a;
        logic       v;
        logic [7:0] b;
        c   = cfg(k);
        msk = (1 << c.d) - 1;
        n   = 0;
        t   = 0;
        sel = 2'(k);
        start_v[k] = 1'b1;
        @(negedge clk);
        start_v[k] = 1'b0;
        check("load_in_ready", 32'(o.in_ready), 1);
        check("load_busy", 32'(o.busy), 1);
        check("load_core_reset", 32'(o.core_reset), 1);
        check("load_timeout_clr", 32'(o.timeout), 0);
        check("load_cycles_clr", 32'(o.cyc), 0);
        while (n < c.ll && t < 40 * c.ll + 50) begin
            if (abort_after >= 0 && n == abort_after) break;
            v = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            b = 8'($urandom);
            in_valid  = v;
            in_data   = b;
            core_done = 1'($urandom_range(0, 1));
            #1;
            check("load_we", 32'(o.mem_we), 32'(v));
            if (v) begin
                a = (c.lb + n) & msk;
                check("load_addr", 32'(o.addr), a);
                ref_mem[k][8'(a)] = b;
                n++;
            end
            @(negedge clk);
            t++;
        end
        in_valid  = 1'b0;
        core_done = 1'b0;
        n_loaded  = n;
        if (abort_after < 0) begin
            check("load_len", n, c.ll);
            check("run_core_reset", 32'(o.core_reset), 0);
            check("run_mem_own", 32'(o.mem_own), 0);
            check("run_in_ready", 32'(o.in_ready), 0);
        end
    endtask

    task automatic do_run(input int k, input int n_done, output int exp_cyc, output bit exp_to);
        cfg_t c;
        int   exp_run;
        int   r;
        c = cfg(k);
        // Done in RUN cycle n is honoured while n <= limit+1; otherwise the limit cycle times out.
        if (n_done >= 1 && n_done <= c.mx + 1) begin
            exp_run = n_done;
            exp_cyc = (n_done < c.mx) ? n_done : c.mx;
            exp_to  = 1'b0;
        end else begin
            exp_run = c.mx + 1;
            exp_cyc = c.mx;
            exp_to  = 1'b1;
        end
        r = 1;
        while (o.core_reset == 1'b0 && r <= c.mx + 8) begin
            core_done  = (r == n_done);
            start_v[k] = 1'($urandom_range(0, 1));
            @(negedge clk);
            r++;
        end
        core_done  = 1'b0;
        start_v[k] = 1'b0;
        check("run_cycles", r - 1, exp_run);
        check("unload_core_reset", 32'(o.core_reset), 1);
        check("unload_mem_own", 32'(o.mem_own), 1);
        check("unload_cycle_count", 32'(o.cyc), exp_cyc);
        check("unload_timeout", 32'(o.timeout), 32'(exp_to));
        check("unload_busy", 32'(o.busy), 1);
    endtask

    task automatic do_unload(input int k, input int mode, input int exp_cyc, input bit exp_to);
        cfg_t c;
        int   msk;
        int   j;
        int   t;
        int   a;
        logic rdy;
        c   = cfg(k);
        msk = (1 << c.d) - 1;
        j   = 0;
        t   = 0;
        while (j < c.ul && t < 40 * c.ul + 50) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (t % 4 == 0) || (t % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready  = rdy;
            core_done  = 1'($urandom_range(0, 1));
            start_v[k] = 1'($urandom_range(0, 1));
            #1;
            a = (c.ub + j) & msk;
            check("unload_valid", 32'(o.out_valid), 1);
            check("unload_addr", 32'(o.addr), a);
            check("unload_data", 32'(o.out_data), 32'(ref_mem[k][8'(a)]));
            check("unload_we", 32'(o.mem_we), 0);
            if (rdy) j++;
            @(negedge clk);
            t++;
        end
        out_ready  = 1'b0;
        core_done  = 1'b0;
        start_v[k] = 1'b0;
        check("unload_count", j, c.ul);
        check("fin_finished", 32'(o.finished), 1);
        check("fin_out_valid", 32'(o.out_valid), 0);
        check("fin_busy", 32'(o.busy), 0);
        check("fin_core_reset", 32'(o.core_reset), 1);
        repeat (2) @(negedge clk);
        check("fin_hold_finished", 32'(o.finished), 1);
        check("fin_hold_cycles", 32'(o.cyc), exp_cyc);
        check("fin_hold_timeout", 32'(o.timeout), 32'(exp_to));
    endtask

    task automatic txn(input int k, input bit rnd_valid, input int n_done, input int umode);
        cfg_t c;
        int   w0;
        int   nl;
        int   ec;
        bit   et;
        c  = cfg(k);
        w0 = wr_count(k);
        do_load(k, rnd_valid, -1, nl);
        do_run(k, n_done, ec, et);
        do_unload(k, umode, ec, et);
        check("txn_writes", wr_count(k) - w0, c.ll);
        check_mem(k);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   nl;
        int   w0;
        int   kk;
        cfg_t cc;
        n_checks  = 0;
        n_fail    = 0;
        start_v   = '0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        core_done = 1'b0;
        sel       = 2'd0;
        rst_n     = 1'b0;
        mem_clr   = 1'b1;
        for (int k = 0; k < 3; k++)
            for (int a = 0; a < 256; a++) ref_mem[k][8'(a)] = 8'h00;
        repeat (3) @(negedge clk);
        mem_clr = 1'b0;
        rst_n   = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 3; k++) begin
            sel = 2'(k);
            #1;
            check("rst_core_reset", 32'(o.core_reset), 1);
            check("rst_mem_own", 32'(o.mem_own), 1);
            check("rst_in_ready", 32'(o.in_ready), 0);
            check("rst_out_valid", 32'(o.out_valid), 0);
            check("rst_mem_we", 32'(o.mem_we), 0);
            check("rst_busy", 32'(o.busy), 0);
            check("rst_finished", 32'(o.finished), 0);
            check("rst_timeout", 32'(o.timeout), 0);
            check("rst_cycles", 32'(o.cyc), 0);
        end
        @(negedge clk);

        // Load 4 bytes back-to-back, Done in the 4th RUN cycle, 1,0,0,1 backpressure.
        txn(0, 1'b0, 4, 1);

        // Reset after two load bytes, then a fresh load from the base address.
        w0 = wr_count(0);
        do_load(0, 1'b0, 2, nl);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_in_ready", 32'(o.in_ready), 0);
        check("abort_core_reset", 32'(o.core_reset), 1);
        check("abort_busy", 32'(o.busy), 0);
        check("abort_mem_own", 32'(o.mem_own), 1);
        check("abort_writes", wr_count(0) - w0, 2);
        check_mem(0);

        // Timeout, then a restart from FIN where Done and the limit coincide.
        txn(0, 1'b1, 0, 2);
        txn(0, 1'b0, 11, 0);

        // Address wrap past the top of memory, and a full 2^D image.
        txn(1, 1'b1, 7, 1);
        txn(2, 1'b0, 0, 2);
        txn(2, 1'b1, 3, 1);

        for (int i = 0; i < 8; i++) begin
            kk = $urandom_range(0, 2);
            cc = cfg(kk);
            txn(kk, 1'b1, $urandom_range(0, cc.mx + 2), $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
